uart_rx_sequencer: RTL and testbench



---
 rtl/uart_rx_sequencer_if.sv | 28 ++
 rtl/uart_rx_sequencer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Receive-side byte handshake between the UART RX sequencer and its consumer.
// master: the sequencer (produces bytes and error pulses)
// slave : the byte consumer (drives rx_ready)
interface uart_rx_sequencer_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 framing_error;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output framing_error,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  framing_error,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: line synchroniser, bit-timing divider, start/data/stop
// framing and a one-byte holding register on a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | line idle, waiting for rx_s to fall
// S_START    | timing half a bit, start bit re-checked at mid-bit
// S_DATA     | sampling DATA_BITS data bits at one-bit spacing, LSB first
// S_STOP     | one bit period, then stop bit sampled
// S_WAIT_HIGH| stop bit was 0; hold off until the line returns high
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_D,
    uart_rx_sequencer_if.master  rx_bus,
    output logic                 busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_D;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, timing, shift and holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    // Frame sequencing plus delivery into the holding register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completed byte lands one cycle after the stop sample; an accept in
        // that same cycle frees the holding register in time for it.
        if (deliver_q) begin
            if (!valid_q || rx_bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rx_bus.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_bus.rx_data       = data_q;
    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.framing_error = fe_q;
    assign rx_bus.overrun       = ov_q;
    assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: frame-level transmitter, event-based reference
// model of deliveries / error pulses / busy windows, per-cycle output compare.
module tb_uart_rx_sequencer;
    localparam int C      = 16;
    localparam int D      = 8;
    // Cycles from the posedge preceding the start-bit falling edge to the stop
    // sample: 2 sync + 1 idle detect + half bit + (D+1) full bits.
    localparam int SP_OFF = 3 + C / 2 + (D + 1) * C;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx_D  = 1'b1;
    logic busy;

    uart_rx_sequencer_if #(.DATA_BITS(D)) bus_if ();

    uart_rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clock  (clock),
        .reset  (reset),
        .rx_D   (rx_D),
        .rx_bus (bus_if),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        bit         fe;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    ev_t  evq[$];
    win_t busy_win[$];

    int         cyc     = 0;
    int         n_chk   = 0;
    int         n_fail  = 0;
    int         n_fe    = 0;
    int         n_ov    = 0;
    int         last_t0 = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         rnd_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Reference model update and compare, #1 after every active edge.
    always @(posedge clock) begin : cmp_p
        bit         rdy_e;
        bit         rst_e;
        bit         dlv;
        bit         fe_exp;
        bit         ov_exp;
        bit         busy_exp;
        logic [7:0] dlv_data;
        ev_t        ev;
        cyc++;
        rdy_e = bus_if.rx_ready;
        rst_e = reset;
        #1;
        fe_exp   = 1'b0;
        ov_exp   = 1'b0;
        dlv      = 1'b0;
        dlv_data = 8'h00;
        if (rst_e) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
            foreach (busy_win[i]) begin
                if (busy_win[i].hi >= cyc) busy_win[i].hi = cyc - 1;
            end
        end else begin
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.fe) fe_exp = 1'b1;
                else begin
                    dlv      = 1'b1;
                    dlv_data = ev.data;
                end
            end
            if (dlv) begin
                if (!m_valid || rdy_e) begin
                    m_valid = 1'b1;
                    m_data  = dlv_data;
                end else begin
                    ov_exp = 1'b1;
                end
            end else if (m_valid && rdy_e) begin
                m_valid = 1'b0;
            end
        end
        busy_exp = 1'b0;
        foreach (busy_win[i]) begin
            if (cyc >= busy_win[i].lo && cyc <= busy_win[i].hi) busy_exp = 1'b1;
        end
        chk("rx_valid", 32'(bus_if.rx_valid), 32'(m_valid));
        chk("rx_data", 32'(bus_if.rx_data), 32'(m_data));
        chk("framing_error", 32'(bus_if.framing_error), 32'(fe_exp));
        chk("overrun", 32'(bus_if.overrun), 32'(ov_exp));
        chk("busy", 32'(busy), 32'(busy_exp));
        if (bus_if.framing_error === 1'b1) n_fe++;
        if (bus_if.overrun === 1'b1) n_ov++;
    end

    // All line drives happen on negedges.
    task automatic drive_bit(input bit v, input int n);
        rx_D = v;
        repeat (n) @(negedge clock);
    endtask

    // Sends one frame starting at the current negedge and registers the
    // expected outcome (delivery or framing error) and busy window.
    task automatic tx_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
        int   t0;
        int   wi;
        win_t w;
        t0      = cyc;
        last_t0 = t0;
        evq.push_back('{t0 + SP_OFF + (stop_ok ? 1 : 0), !stop_ok, b});
        w.lo = t0 + 3;
        w.hi = stop_ok ? t0 + SP_OFF - 1 : 32'h7fff_ffff;
        busy_win.push_back(w);
        wi = busy_win.size() - 1;
        drive_bit(1'b0, C);
        for (int i = 0; i < D; i++) drive_bit(b[i], C);
        if (stop_ok) begin
            drive_bit(1'b1, C);
        end else begin
            drive_bit(1'b0, C + low_hold);
            busy_win[wi].hi = cyc + 2;
            drive_bit(1'b1, 4);
        end
    endtask

    task automatic tx_glitch(input int n_low);
        win_t w;
        w.lo = cyc + 3;
        w.hi = cyc + 2 + C / 2;
        busy_win.push_back(w);
        drive_bit(1'b0, n_low);
        drive_bit(1'b1, C);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ov0;
        int e2;
        bus_if.rx_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1, 5);
        chk("reset_valid", 32'(bus_if.rx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // 1: single clean frame, latency window
        fork
            tx_frame(8'hA5, 1'b1, 0);
            begin
                int k;
                for (k = 0; k < 400; k++) begin
                    @(posedge clock);
                    #2;
                    if (bus_if.rx_valid === 1'b1) break;
                end
                chk_rng("t1_latency", cyc - last_t0, SP_OFF, SP_OFF + 2);
                chk("t1_data", 32'(bus_if.rx_data), 32'h0000_00A5);
            end
        join
        drive_bit(1'b1, 10);

        // 2: start glitch, then a real frame
        tx_glitch(4);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_valid", 32'(bus_if.rx_valid), 32'd0);
        tx_frame(8'h3C, 1'b1, 0);
        drive_bit(1'b1, 4);
        chk("t2_data", 32'(bus_if.rx_data), 32'h0000_003C);

        // 3: framing error with line held low, then recovery
        fe0 = n_fe;
        tx_frame(8'h55, 1'b0, 40 - C);
        chk("t3_fe_count", 32'(n_fe - fe0), 32'd1);
        chk("t3_data_kept", 32'(bus_if.rx_data), 32'h0000_003C);
        tx_frame(8'h0F, 1'b1, 0);
        drive_bit(1'b1, 4);
        chk("t3_data", 32'(bus_if.rx_data), 32'h0000_000F);

        // 4: overrun while the holding register is full
        bus_if.rx_ready = 1'b0;
        ov0 = n_ov;
        tx_frame(8'h11, 1'b1, 0);
        tx_frame(8'h22, 1'b1, 0);
        drive_bit(1'b1, 4);
        chk("t4_ov_count", 32'(n_ov - ov0), 32'd1);
        chk("t4_data", 32'(bus_if.rx_data), 32'h0000_0011);
        chk("t4_valid", 32'(bus_if.rx_valid), 32'd1);
        bus_if.rx_ready = 1'b1;
        @(negedge clock);
        bus_if.rx_ready = 1'b0;
        chk("t4_valid_drop", 32'(bus_if.rx_valid), 32'd0);

        // 5: back-to-back frames, accept coinciding with second delivery
        e2 = cyc + (D + 2) * C + SP_OFF + 1;
        ov0 = n_ov;
        fork
            begin
                tx_frame(8'h00, 1'b1, 0);
                tx_frame(8'hFF, 1'b1, 0);
                tx_frame(8'h81, 1'b1, 0);
            end
            begin
                while (cyc < e2 - 1) @(negedge clock);
                bus_if.rx_ready = 1'b1;
                @(negedge clock);
                chk("t5_valid_kept", 32'(bus_if.rx_valid), 32'd1);
                chk("t5_data_upd", 32'(bus_if.rx_data), 32'h0000_00FF);
            end
        join
        drive_bit(1'b1, 4);
        chk("t5_no_ov", 32'(n_ov - ov0), 32'd0);
        chk("t5_data", 32'(bus_if.rx_data), 32'h0000_0081);

        // 6: reset during data bit 4 drops the held byte and the frame
        bus_if.rx_ready = 1'b0;
        tx_frame(8'h5A, 1'b1, 0);
        drive_bit(1'b1, 4);
        chk("t6_held", 32'(bus_if.rx_valid), 32'd1);
        fork
            tx_frame(8'hF3, 1'b1, 0);
            begin
                repeat (5 * C + C / 2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("t6_rst_valid", 32'(bus_if.rx_valid), 32'd0);
                chk("t6_rst_data", 32'(bus_if.rx_data), 32'd0);
                chk("t6_rst_busy", 32'(busy), 32'd0);
            end
        join
        drive_bit(1'b1, 4);
        bus_if.rx_ready = 1'b1;
        tx_frame(8'h9A, 1'b1, 0);
        drive_bit(1'b1, 4);
        chk("t6_data", 32'(bus_if.rx_data), 32'h0000_009A);

        // Randomised frames, stop errors, gaps and consumer back-pressure
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    tx_frame(8'($urandom), ($urandom_range(0, 9) != 0), $urandom_range(0, 20));
                    drive_bit(1'b1, $urandom_range(0, 12));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clock);
                    bus_if.rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        bus_if.rx_ready = 1'b1;
        drive_bit(1'b1, 20);
        chk("events_drained", 32'(evq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
